// File: rtl/cwc_capture_reader_if.sv
// Bundle of control, capture-RAM read port and byte stream signals for the capture reader.
// master: the reader itself; slave: the capture RAM, hub link and controller around it.
interface cwc_capture_reader_if #(
    parameter int unsigned DATA_W = 90,
    parameter int unsigned ADDR_W = 12
);
    logic              start;
    logic              abort;
    logic [ADDR_W-1:0] start_addr;
    logic [ADDR_W:0]   sample_cnt;
    logic              ram_ren;
    logic [ADDR_W-1:0] ram_raddr;
    logic [DATA_W-1:0] ram_rdata;
    logic [7:0]        tx_data;
    logic              tx_valid;
    logic              tx_ready;
    logic              tx_last;
    logic              busy;
    logic              done;

    modport master (
        input  start, abort, start_addr, sample_cnt, ram_rdata, tx_ready,
        output ram_ren, ram_raddr, tx_data, tx_valid, tx_last, busy, done
    );

    modport slave (
        output start, abort, start_addr, sample_cnt, ram_rdata, tx_ready,
        input  ram_ren, ram_raddr, tx_data, tx_valid, tx_last, busy, done
    );
endinterface

// File: rtl/cwc_capture_reader.sv
// Reads captured samples oldest-first from the circular capture RAM and streams each one
// out LSB byte first on a valid/ready byte stream.
module cwc_capture_reader #(
    parameter int unsigned DATA_W = 90,
    parameter int unsigned DEPTH  = 4096,
    parameter int unsigned ADDR_W = 12
) (
    input logic                 clk,
    input logic                 rst,
    cwc_capture_reader_if.master bus
);
    localparam int unsigned NBYTES  = (DATA_W + 7) / 8;
    localparam int unsigned SHIFT_W = NBYTES * 8;
    localparam int unsigned IDX_W   = $clog2(NBYTES);

    typedef enum logic [2:0] {StIdle, StFetch, StWait, StSend, StFinish} state_e;

    state_e             state_q, state_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [ADDR_W:0]    remaining_q, remaining_d;
    logic [SHIFT_W-1:0] shift_q, shift_d;
    logic [IDX_W-1:0]   byte_idx_q, byte_idx_d;

    logic            busy_w;
    logic            last_byte;
    logic [ADDR_W:0] cnt_clamped;

    assign busy_w      = (state_q == StFetch) || (state_q == StWait) || (state_q == StSend);
    assign last_byte   = (byte_idx_q == IDX_W'(NBYTES - 1));
    assign cnt_clamped = (bus.sample_cnt > (ADDR_W + 1)'(DEPTH)) ? (ADDR_W + 1)'(DEPTH)
                                                                 : bus.sample_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            addr_q      <= '0;
            remaining_q <= '0;
            shift_q     <= '0;
            byte_idx_q  <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            remaining_q <= remaining_d;
            shift_q     <= shift_d;
            byte_idx_q  <= byte_idx_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        remaining_d = remaining_q;
        shift_d     = shift_q;
        byte_idx_d  = byte_idx_q;
        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    addr_d      = bus.start_addr;
                    remaining_d = cnt_clamped;
                    state_d     = (cnt_clamped == '0) ? StFinish : StFetch;
                end
            end
            StFetch: state_d = StWait;
            StWait: begin
                shift_d    = SHIFT_W'(bus.ram_rdata);
                byte_idx_d = '0;
                state_d    = StSend;
            end
            StSend: begin
                if (bus.tx_ready) begin
                    shift_d    = shift_q >> 8;
                    byte_idx_d = byte_idx_q + 1'b1;
                    if (last_byte) begin
                        remaining_d = remaining_q - 1'b1;
                        // DEPTH is a power of two, so the natural ADDR_W overflow is the wrap.
                        addr_d      = addr_q + 1'b1;
                        state_d     = (remaining_q != (ADDR_W + 1)'(1)) ? StFetch : StFinish;
                    end
                end
            end
            StFinish: state_d = StIdle;
            default:  state_d = StIdle;
        endcase
        // Abort outranks any handshake in the same cycle and suppresses done.
        if (bus.abort && busy_w) begin
            state_d = StIdle;
        end
    end

    always_comb begin
        bus.ram_ren   = (state_q == StFetch);
        bus.ram_raddr = addr_q;
        bus.tx_valid  = (state_q == StSend);
        bus.tx_data   = (state_q == StSend) ? shift_q[7:0] : 8'h00;
        bus.tx_last   = (state_q == StSend) && last_byte && (remaining_q == (ADDR_W + 1)'(1));
        bus.busy      = busy_w;
        bus.done      = (state_q == StFinish);
    end
endmodule

// File: tb/tb_cwc_capture_reader.sv
// Directed bench for cwc_capture_reader: RAM model, stream monitor and per-scenario checks.
module tb_cwc_capture_reader;
    logic clk = 1'b0;
    logic rst = 1'b1;

    cwc_capture_reader_if #(.DATA_W(90), .ADDR_W(12)) bus_if ();

    cwc_capture_reader #(.DATA_W(90), .DEPTH(4096), .ADDR_W(12)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Byte k of the word stored at address a; byte 11 holds only the two top sample bits.
    function automatic logic [7:0] pat_byte(input logic [11:0] a, input int k);
        if (k == 11) return {6'b0, a[1:0] ^ 2'b10};
        return (a[7:0] ^ {a[11:8], 4'h0}) + 8'(k * 29 + 1);
    endfunction

    function automatic logic [89:0] pat_word(input logic [11:0] a);
        logic [89:0] w;
        w = '0;
        for (int k = 0; k < 11; k++) w[8*k +: 8] = pat_byte(a, k);
        w[89:88] = a[1:0] ^ 2'b10;
        return w;
    endfunction

    always_ff @(posedge clk) begin
        if (bus_if.ram_ren) bus_if.ram_rdata <= pat_word(bus_if.ram_raddr);
    end

    int          edge_cnt = 0;
    int          t0 = 0;
    logic [7:0]  rx_q[$];
    int          last_idx_q[$];
    logic [11:0] rd_addr_q[$];
    int          done_cnt, done_cyc, first_cyc, stall_err, stall_cycles, done_busy_err;
    logic        prev_stall = 1'b0;
    logic [7:0]  prev_data = 8'h00;
    logic        prev_last = 1'b0;

    always_ff @(posedge clk) edge_cnt <= edge_cnt + 1;

    always @(negedge clk) begin
        int cyc;
        cyc = edge_cnt - t0 + 1;
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall && (!bus_if.tx_valid || bus_if.tx_data != prev_data ||
                               bus_if.tx_last != prev_last)) stall_err++;
            prev_stall = bus_if.tx_valid && !bus_if.tx_ready;
            prev_data  = bus_if.tx_data;
            prev_last  = bus_if.tx_last;
            if (prev_stall) stall_cycles++;
            if (bus_if.tx_valid && bus_if.tx_ready) begin
                if (rx_q.size() == 0) first_cyc = cyc;
                if (bus_if.tx_last) last_idx_q.push_back(rx_q.size());
                rx_q.push_back(bus_if.tx_data);
            end
            if (bus_if.ram_ren) rd_addr_q.push_back(bus_if.ram_raddr);
            if (bus_if.done) begin
                done_cnt++;
                done_cyc = cyc;
                if (bus_if.busy) done_busy_err++;
            end
        end
    end

    task automatic clear_mon();
        rx_q.delete();
        last_idx_q.delete();
        rd_addr_q.delete();
        done_cnt      = 0;
        done_cyc      = -1;
        first_cyc     = -1;
        stall_err     = 0;
        stall_cycles  = 0;
        done_busy_err = 0;
    endtask

    // Returns with t0 set so that the cycle after the accepting edge counts as cycle 1.
    task automatic do_start(input logic [11:0] sa, input logic [12:0] cnt);
        clear_mon();
        @(posedge clk); #1;
        bus_if.start_addr = sa;
        bus_if.sample_cnt = cnt;
        bus_if.start      = 1'b1;
        @(posedge clk); #1;
        t0           = edge_cnt;
        bus_if.start = 1'b0;
    endtask

    task automatic wait_done(input int max_cyc, input string tag);
        int n;
        n = 0;
        while (done_cnt == 0 && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        check({tag, "_done_pulses"}, done_cnt, 1);
        check({tag, "_busy_in_done"}, done_busy_err, 0);
    endtask

    task automatic verify_bytes(input logic [11:0] sa, input int n, input string tag);
        int err;
        int lpos;
        err = 0;
        check({tag, "_byte_count"}, rx_q.size(), n * 12);
        for (int j = 0; j < rx_q.size() && j < n * 12; j++) begin
            if (rx_q[j] != pat_byte(12'(sa + 12'(j / 12)), j % 12)) err++;
        end
        check({tag, "_byte_errors"}, err, 0);
        check({tag, "_last_count"}, last_idx_q.size(), 1);
        lpos = (last_idx_q.size() > 0) ? last_idx_q[0] : -1;
        check({tag, "_last_pos"}, lpos, n * 12 - 1);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [15:0] lfsr;
        logic [7:0]  b;
        int          n;
        bus_if.start      = 1'b0;
        bus_if.abort      = 1'b0;
        bus_if.start_addr = '0;
        bus_if.sample_cnt = '0;
        bus_if.tx_ready   = 1'b1;
        clear_mon();
        #12;
        check("reset_outputs", {bus_if.ram_ren, bus_if.ram_raddr, bus_if.tx_data, bus_if.tx_valid,
                                bus_if.tx_last, bus_if.busy, bus_if.done}, '0);
        @(negedge clk);
        rst = 1'b0;

        // Two samples from address 0, stream always ready.
        do_start(12'd0, 13'd2);
        wait_done(100, "two");
        verify_bytes(12'd0, 2, "two");
        check("two_first_cycle", first_cyc, 3);
        check("two_done_cycle", done_cyc, 29);
        b = rx_q[0];
        check("two_byte0", b, 8'h01);
        b = rx_q[11];
        check("two_byte11", b, 8'h02);

        // Address wrap at the top of the buffer.
        do_start(12'd4094, 13'd4);
        wait_done(200, "wrap");
        check("wrap_reads", rd_addr_q.size(), 4);
        check("wrap_addrs", {rd_addr_q[0], rd_addr_q[1], rd_addr_q[2], rd_addr_q[3]},
              {12'd4094, 12'd4095, 12'd0, 12'd1});
        verify_bytes(12'd4094, 4, "wrap");

        // Pseudo-random backpressure.
        lfsr = 16'hACE1;
        do_start(12'd100, 13'd3);
        n = 0;
        while (done_cnt == 0 && n < 500) begin
            @(posedge clk); #1;
            lfsr = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
            bus_if.tx_ready = lfsr[0];
            n++;
        end
        bus_if.tx_ready = 1'b1;
        wait_done(10, "bp");
        verify_bytes(12'd100, 3, "bp");
        check("bp_stall_stable", stall_err, 0);
        check("bp_stalls_seen", stall_cycles > 0, 1'b1);

        // Zero count: done without bytes or RAM reads.
        do_start(12'd5, 13'd0);
        repeat (6) @(negedge clk);
        check("zero_done_pulses", done_cnt, 1);
        check("zero_done_early", (done_cyc >= 1) && (done_cyc <= 2), 1'b1);
        check("zero_bytes", rx_q.size(), 0);
        check("zero_reads", rd_addr_q.size(), 0);

        // Count above depth clamps to the whole buffer.
        do_start(12'd7, 13'd5000);
        wait_done(60000, "clamp");
        check("clamp_reads", rd_addr_q.size(), 4096);
        verify_bytes(12'd7, 4096, "clamp");

        // Abort during the third sample, then a fresh one-sample run.
        do_start(12'd0, 13'd10);
        n = 0;
        while (rx_q.size() < 26 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("abort_reached_s3", rx_q.size() >= 26, 1'b1);
        @(posedge clk); #1;
        bus_if.abort = 1'b1;
        @(posedge clk); #1;
        bus_if.abort = 1'b0;
        check("abort_outputs", {bus_if.tx_valid, bus_if.busy, bus_if.ram_ren}, 3'b000);
        repeat (30) @(negedge clk);
        check("abort_no_done", done_cnt, 0);
        do_start(12'd20, 13'd1);
        wait_done(50, "post_abort");
        verify_bytes(12'd20, 1, "post_abort");

        // Asynchronous reset mid-send, checked before any further clock edge.
        do_start(12'd0, 13'd3);
        n = 0;
        while (rx_q.size() < 5 && n < 100) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        check("async_reset_outputs", {bus_if.ram_ren, bus_if.ram_raddr, bus_if.tx_data,
                                      bus_if.tx_valid, bus_if.tx_last, bus_if.busy, bus_if.done},
              '0);
        @(negedge clk);
        rst = 1'b0;
        do_start(12'd50, 13'd1);
        wait_done(50, "post_reset");
        verify_bytes(12'd50, 1, "post_reset");
        check("post_reset_first_cycle", first_cyc, 3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
